// File: rtl/aes_pkg.sv
// Shared AES definitions for the round-key scheduler.
// Holds the round count, key width, FSM state encoding, the RCON lookup
// and word/byte extraction helpers for the MSB-first 128-bit layout.
package aes_pkg;

   localparam int unsigned NR    = 10;
   localparam int unsigned KEY_W = 128;
   localparam int unsigned IDX_W = 4;
   localparam int unsigned WORD_W = 32;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_e;

   // Round constant for the transition round_idx -> round_idx+1.
   function automatic logic [7:0] rcon(input logic [IDX_W-1:0] idx);
      logic [7:0] rc;
      case (idx)
         4'd0:    rc = 8'h01;
         4'd1:    rc = 8'h02;
         4'd2:    rc = 8'h04;
         4'd3:    rc = 8'h08;
         4'd4:    rc = 8'h10;
         4'd5:    rc = 8'h20;
         4'd6:    rc = 8'h40;
         4'd7:    rc = 8'h80;
         4'd8:    rc = 8'h1b;
         4'd9:    rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

   // Word i of a 128-bit key; word 0 is the most significant.
   function automatic logic [WORD_W-1:0] key_word(input logic [KEY_W-1:0] k,
                                                  input logic [1:0]       i);
      return k[(KEY_W - 1) - WORD_W * int'(i) -: WORD_W];
   endfunction

   // Byte i of a 32-bit word; byte 0 is the most significant.
   function automatic logic [7:0] word_byte(input logic [WORD_W-1:0] w,
                                            input logic [1:0]        i);
      return w[(WORD_W - 1) - 8 * int'(i) -: 8];
   endfunction

endpackage

// File: rtl/aes128_key_sched_ctrl_if.sv
// Key-in / round-key-out handshake bundle for the AES-128 key scheduler.
// master: key source and round datapath side; slave: the scheduler.
interface aes128_key_sched_ctrl_if;

   logic                         key_valid;
   logic                         key_ready;
   logic [aes_pkg::KEY_W-1:0]    cipher_key;
   logic                         rk_valid;
   logic                         rk_ready;
   logic [aes_pkg::KEY_W-1:0]    round_key;
   logic [aes_pkg::IDX_W-1:0]    round_idx;
   logic                         rk_last;
   logic                         busy;

   modport master (
      output key_valid, cipher_key, rk_ready,
      input  key_ready, rk_valid, round_key, round_idx, rk_last, busy
   );

   modport slave (
      input  key_valid, cipher_key, rk_ready,
      output key_ready, rk_valid, round_key, round_idx, rk_last, busy
   );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, 8-bit in / 8-bit out.
// Ports: in_i - input byte; out_o - substituted byte.
module aes_sbox (
   input  logic [7:0] in_i,
   output logic [7:0] out_o
);

   // Entry for byte value v sits at bits [2047-8v -: 8].
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign out_o = SBOX_TBL[11'd2047 - {in_i, 3'b000} -: 8];

endmodule

// File: rtl/aes128_key_sched_ctrl.sv
// Iterative AES-128 round-key scheduler: accepts a cipher key and emits
// round keys 0..10, one per rk handshake, tagged with the round index.
// Only the current round key is stored; the next one is derived on the fly.
// Ports: clk, rst (sync, active-high); bus_if (slave) carries key_valid/
// key_ready/cipher_key in, rk_valid/rk_ready/round_key/round_idx/rk_last/busy out.
module aes128_key_sched_ctrl #(
   parameter int unsigned NR    = 10,
   parameter int unsigned KEY_W = 128
) (
   input  logic                      clk,
   input  logic                      rst,
   aes128_key_sched_ctrl_if.slave    bus_if
);

   // Only the AES-128 configuration exists.
   if (NR != aes_pkg::NR || KEY_W != aes_pkg::KEY_W) begin : g_bad_cfg
      $error("aes128_key_sched_ctrl supports only NR=10 and KEY_W=128");
   end

   aes_pkg::state_e                   state_q;
   logic [aes_pkg::KEY_W-1:0]         key_q;
   logic [aes_pkg::IDX_W-1:0]         idx_q;
   logic                              vld_q;

   logic [aes_pkg::WORD_W-1:0]        w0, w1, w2, w3;
   logic [aes_pkg::WORD_W-1:0]        rot_w, sub_w, t_w;
   logic [aes_pkg::WORD_W-1:0]        w4, w5, w6, w7;
   logic [aes_pkg::KEY_W-1:0]         key_d;

   // Next round key from the current one.
   assign w0    = aes_pkg::key_word(key_q, 2'd0);
   assign w1    = aes_pkg::key_word(key_q, 2'd1);
   assign w2    = aes_pkg::key_word(key_q, 2'd2);
   assign w3    = aes_pkg::key_word(key_q, 2'd3);
   assign rot_w = {w3[23:0], w3[31:24]};

   for (genvar b = 0; b < 4; b++) begin : g_subword
      aes_sbox u_sbox (
         .in_i  (aes_pkg::word_byte(rot_w, 2'(b))),
         .out_o (sub_w[31 - 8*b -: 8])
      );
   end

   assign t_w   = sub_w ^ {aes_pkg::rcon(idx_q), 24'h000000};
   assign w4    = w0 ^ t_w;
   assign w5    = w1 ^ w4;
   assign w6    = w2 ^ w5;
   assign w7    = w3 ^ w6;
   assign key_d = {w4, w5, w6, w7};

   // Sequencer: load in IDLE, advance one key per handshake in EMIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= aes_pkg::ST_IDLE;
         vld_q   <= 1'b0;
         idx_q   <= '0;
         key_q   <= '0;
      end else begin
         case (state_q)
            aes_pkg::ST_IDLE: begin
               if (bus_if.key_valid) begin
                  key_q   <= bus_if.cipher_key;
                  idx_q   <= '0;
                  vld_q   <= 1'b1;
                  state_q <= aes_pkg::ST_EMIT;
               end
            end
            aes_pkg::ST_EMIT: begin
               if (vld_q && bus_if.rk_ready) begin
                  if (idx_q == 4'(NR)) begin
                     // round_key keeps rk10; it is don't-care while invalid.
                     vld_q   <= 1'b0;
                     idx_q   <= '0;
                     state_q <= aes_pkg::ST_IDLE;
                  end else begin
                     key_q <= key_d;
                     idx_q <= idx_q + 4'd1;
                  end
               end
            end
            default: begin
               vld_q   <= 1'b0;
               idx_q   <= '0;
               state_q <= aes_pkg::ST_IDLE;
            end
         endcase
      end
   end

   // key_ready is gated by rst so no key is taken in a reset cycle.
   assign bus_if.key_ready = !rst && (state_q == aes_pkg::ST_IDLE);
   assign bus_if.rk_valid  = vld_q;
   assign bus_if.round_key = key_q;
   assign bus_if.round_idx = idx_q;
   assign bus_if.rk_last   = vld_q && (idx_q == 4'(NR));
   assign bus_if.busy      = (state_q == aes_pkg::ST_EMIT);

endmodule

// File: tb/tb_aes128_key_sched_ctrl.sv
// Self-checking bench for aes128_key_sched_ctrl: FIPS-197 known answers,
// random keys with random backpressure, held key_valid, and mid-run reset.
module tb_aes128_key_sched_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   aes128_key_sched_ctrl_if bus ();

   aes128_key_sched_ctrl #(.NR(10), .KEY_W(128)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_if (bus.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]   sbox_m [256];
   logic [127:0] exp_rk [11];

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] y;
      p = 8'h00;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = xtime(x);
         y = y >> 1;
      end
      return p;
   endfunction

   // S-box from its definition: GF(2^8) inverse followed by the affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         for (int b = 1; b < 256; b++)
            if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         sbox_m[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                         ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   endtask

   // Full FIPS-197 key expansion into 44 words, grouped as 11 round keys.
   task automatic model_expand(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] tmp;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]};
            tmp = tmp ^ {rc, 24'h000000};
            rc  = xtime(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // One key through the scheduler, checked every cycle until rk10 is taken.
   task automatic run_seq(input logic [127:0] key, input int pct,
                          input bit hold, input logic [127:0] nkey,
                          input bit kat1_en, input logic [127:0] kat1,
                          input bit kat10_en, input logic [127:0] kat10);
      int e;
      int cyc;
      bit rr;
      #1;
      model_expand(key);
      check("key_ready_idle", 128'(bus.key_ready), 128'd1);
      bus.cipher_key = key;
      bus.key_valid  = 1'b1;
      @(negedge clk);
      if (hold) bus.cipher_key = nkey;
      else begin
         bus.key_valid  = 1'b0;
         bus.cipher_key = '0;
      end
      e   = 0;
      cyc = 0;
      while (e < 11 && cyc < 400) begin
         check("rk_valid", 128'(bus.rk_valid), 128'd1);
         check("round_idx", 128'(bus.round_idx), 128'(e));
         check("round_key", bus.round_key, exp_rk[e]);
         check("rk_last", 128'(bus.rk_last), 128'(e == 10));
         check("busy", 128'(bus.busy), 128'd1);
         check("key_ready_busy", 128'(bus.key_ready), 128'd0);
         if (e == 0) check("rk0_is_key", bus.round_key, key);
         if (kat1_en && e == 1) check("kat_idx1", bus.round_key, kat1);
         if (kat10_en && e == 10) check("kat_idx10", bus.round_key, kat10);
         rr = (int'($urandom_range(99)) < pct);
         bus.rk_ready = rr;
         @(negedge clk);
         cyc++;
         if (rr) e++;
      end
      if (e < 11) check("timeout_handshakes", 128'(e), 128'd11);
      bus.rk_ready = 1'b0;
      check("done_rk_valid", 128'(bus.rk_valid), 128'd0);
      check("done_busy", 128'(bus.busy), 128'd0);
      check("done_key_ready", 128'(bus.key_ready), 128'd1);
      check("done_round_idx", 128'(bus.round_idx), 128'd0);
      check("done_rk_last", 128'(bus.rk_last), 128'd0);
   endtask

   initial begin
      logic [127:0] ka;
      logic [127:0] kb;
      build_sbox();

      rst            = 1'b1;
      bus.key_valid  = 1'b0;
      bus.cipher_key = '0;
      bus.rk_ready   = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_rk_valid", 128'(bus.rk_valid), 128'd0);
      check("rst_round_idx", 128'(bus.round_idx), 128'd0);
      check("rst_round_key", bus.round_key, 128'd0);
      check("rst_rk_last", 128'(bus.rk_last), 128'd0);
      check("rst_busy", 128'(bus.busy), 128'd0);
      check("rst_key_ready", 128'(bus.key_ready), 128'd0);
      rst = 1'b0;

      // FIPS-197 A.1 with no backpressure.
      run_seq(128'h2b7e151628aed2a6abf7158809cf4f3c, 100, 1'b0, '0,
              1'b1, 128'ha0fafe1788542cb123a339392a6c7605,
              1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      // FIPS-197 C.1 key with random backpressure.
      run_seq(128'h000102030405060708090a0b0c0d0e0f, 50, 1'b0, '0,
              1'b0, '0, 1'b1, 128'h13111d7fe3944a17f307a78b4d2b30c5);

      // All-zero key.
      run_seq(128'h0, 70, 1'b0, '0,
              1'b1, 128'h62636363626363636263636362636363,
              1'b1, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

      // key_valid held with a second key across the whole first sequence.
      ka = {$urandom, $urandom, $urandom, $urandom};
      kb = {$urandom, $urandom, $urandom, $urandom};
      run_seq(ka, 100, 1'b1, kb, 1'b0, '0, 1'b0, '0);
      run_seq(kb, 60, 1'b0, '0, 1'b0, '0, 1'b0, '0);

      // Reset at round 5 with rk_ready low and key_valid high.
      ka = {$urandom, $urandom, $urandom, $urandom};
      model_expand(ka);
      bus.cipher_key = ka;
      bus.key_valid  = 1'b1;
      @(negedge clk);
      bus.key_valid = 1'b0;
      bus.rk_ready  = 1'b1;
      repeat (5) @(negedge clk);
      check("pre_rst_idx", 128'(bus.round_idx), 128'd5);
      check("pre_rst_key", bus.round_key, exp_rk[5]);
      bus.rk_ready   = 1'b0;
      rst            = 1'b1;
      bus.key_valid  = 1'b1;
      bus.cipher_key = {$urandom, $urandom, $urandom, $urandom};
      #1;
      check("mid_rst_key_ready", 128'(bus.key_ready), 128'd0);
      @(negedge clk);
      check("abort_rk_valid", 128'(bus.rk_valid), 128'd0);
      check("abort_round_idx", 128'(bus.round_idx), 128'd0);
      check("abort_round_key", bus.round_key, 128'd0);
      check("abort_busy", 128'(bus.busy), 128'd0);
      check("abort_rk_last", 128'(bus.rk_last), 128'd0);
      check("abort_key_ready_in_rst", 128'(bus.key_ready), 128'd0);
      @(negedge clk);
      check("rst_no_accept", 128'(bus.rk_valid), 128'd0);
      check("rst_no_busy", 128'(bus.busy), 128'd0);
      rst           = 1'b0;
      bus.key_valid = 1'b0;
      #1;
      check("post_rst_key_ready", 128'(bus.key_ready), 128'd1);
      @(negedge clk);
      run_seq({$urandom, $urandom, $urandom, $urandom}, 80, 1'b0, '0, 1'b0, '0, 1'b0, '0);

      // Random keys with random backpressure.
      for (int n = 0; n < 6; n++)
         run_seq({$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(90)) + 10,
                 1'b0, '0, 1'b0, '0, 1'b0, '0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
